// File: rtl/gmii_tx_pkg.sv
// Shared constants and state encoding for the GMII transmit frame scheduler.
package gmii_tx_pkg;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         CNT_W         = 16;
  // Wide enough for PREAMBLE_LEN up to 15 and IFG_CYCLES up to 63.
  localparam int         TMR_W         = 6;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DRAIN,
    IFG
  } tx_state_e;
endpackage

// File: rtl/gmii_tx_rr_arb.sv
// Two-way round-robin grant; the pointer moves away from the source just served on upd.
module gmii_tx_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       served,
  output logic       gnt_vld,
  output logic       gnt_id
);
  logic prio_q;
  logic prio_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= 1'b0;
    else        prio_q <= prio_d;
  end

  always_comb begin
    prio_d  = upd ? ~served : prio_q;
    gnt_vld = |req;
    gnt_id  = (req == 2'b11) ? prio_q : req[1];
  end
endmodule

// File: rtl/gmii_tx_arbiter.sv
// Frame-level scheduler sharing the GMII TX byte path between two byte-stream sources,
// adding preamble/SFD, enforcing the inter-packet gap and absorbing mid-frame underruns.
module gmii_tx_arbiter
  import gmii_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_CYCLES   = 12
) (
  input  logic             rgmii_txclk,
  input  logic             rst_n,
  input  logic             tx_en,
  input  logic             s0_valid,
  input  logic [7:0]       s0_data,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [7:0]       s1_data,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic [7:0]       gmii_txd,
  output logic             gmii_txdv,
  output logic             tx_busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] underrun_cnt
);
  tx_state_e        state_q, state_d;
  logic             gnt_q, gnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       txd_q, txd_d;
  logic             txdv_q, txdv_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] underrun_cnt_q, underrun_cnt_d;

  logic             arb_vld, arb_id, arb_upd;
  logic             sel_valid, sel_last;
  logic [7:0]       sel_data;

  gmii_tx_rr_arb u_rr_arb (
    .clk     (rgmii_txclk),
    .rst_n   (rst_n),
    .req     ({s1_valid, s0_valid} & {2{tx_en}}),
    .upd     (arb_upd),
    .served  (gnt_q),
    .gnt_vld (arb_vld),
    .gnt_id  (arb_id)
  );

  always_ff @(posedge rgmii_txclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      gnt_q          <= 1'b0;
      tmr_q          <= '0;
      txd_q          <= 8'h00;
      txdv_q         <= 1'b0;
      frame_cnt_q    <= '0;
      underrun_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      gnt_q          <= gnt_d;
      tmr_q          <= tmr_d;
      txd_q          <= txd_d;
      txdv_q         <= txdv_d;
      frame_cnt_q    <= frame_cnt_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  always_comb begin
    sel_valid = gnt_q ? s1_valid : s0_valid;
    sel_last  = gnt_q ? s1_last  : s0_last;
    sel_data  = gnt_q ? s1_data  : s0_data;
  end

  // tmr_q counts preamble bytes already registered, or IFG cycles spent.
  always_comb begin
    state_d        = state_q;
    gnt_d          = gnt_q;
    tmr_d          = tmr_q;
    txd_d          = 8'h00;
    txdv_d         = 1'b0;
    frame_cnt_d    = frame_cnt_q;
    underrun_cnt_d = underrun_cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d   = arb_id;
          state_d = PREAMBLE;
          txd_d   = PREAMBLE_BYTE;
          txdv_d  = 1'b1;
          tmr_d   = TMR_W'(1);
        end
      end
      PREAMBLE: begin
        txdv_d = 1'b1;
        if (tmr_q == TMR_W'(PREAMBLE_LEN)) begin
          txd_d   = SFD_BYTE;
          state_d = DATA;
        end else begin
          txd_d = PREAMBLE_BYTE;
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DATA: begin
        if (sel_valid) begin
          txd_d  = sel_data;
          txdv_d = 1'b1;
          if (sel_last) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            state_d     = IFG;
            tmr_d       = '0;
          end
        end else begin
          underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
          state_d        = DRAIN;
        end
      end
      DRAIN: begin
        if (sel_valid && sel_last) begin
          state_d = IFG;
          tmr_d   = '0;
        end
      end
      IFG: begin
        // The IDLE cycle that follows supplies the last txdv-low cycle of the gap.
        if (tmr_q == TMR_W'(IFG_CYCLES - 1)) state_d = IDLE;
        else                                 tmr_d   = tmr_q + TMR_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_busy      = (state_q != IDLE);
    s0_ready     = ((state_q == DATA) || (state_q == DRAIN)) && !gnt_q;
    s1_ready     = ((state_q == DATA) || (state_q == DRAIN)) &&  gnt_q;
    arb_upd      = (state_q == IFG);
    gmii_txd     = txd_q;
    gmii_txdv    = txdv_q;
    frame_cnt    = frame_cnt_q;
    underrun_cnt = underrun_cnt_q;
  end
endmodule
